rv32i_lite_core: RTL and testbench
==================================

// Module: rv32i_lite_core
// PURPOSE
// - Single-cycle RV32I-subset core: PC, instruction ROM, 32x32 register file, decoder, sign-extend, ALU.
// - Executes R-type and I-type ALU ops only; one instruction retires per clk.
// - Exposes internal datapath signals on *_check outputs for bench visibility.
// - Top of the cpu hierarchy; sub-blocks are internal.
// PARAMETERS
// - IMEM_DEPTH    64    ROM words; indexed by pc[$clog2(IMEM_DEPTH)+1:2]
// - RF_INIT_BASE  3000  base of register reset pattern (see CONFIGURATION)
// PORTS
// - clk                      in   1   rising-edge clock
// - reset                    in   1   asynchronous, active-low reset
// - pc_out_check             out  32  current PC
// - instruction_check        out  32  ROM word at PC
// - alu_op_check             out  3   decoded ALU op
// - register_data_out1_check out  32  RF read port 1 (rs1)
// - register_data_out2_check out  32  RF read port 2 (rs2)
// - b_input_check            out  32  ALU operand B (imm_ext if use_imm, else rs2 data)
// - register_data_in_check   out  32  write-back data (= ALU result)
// - alu_result_check         out  32  ALU result
// - reg_write_check          out  1   RF write enable this cycle
// - imm_ext_check            out  32  sign-extended instr[31:20]
// - use_imm_check            out  1   1 = operand B from immediate
// BEHAVIOUR
// - reset low: PC=0 immediately (async); RF loaded per CONFIGURATION; no writes while low.
// - Each rising clk with reset high: PC<=PC+4 (wraps mod 2^32); if reg_write && rd!=0, x[rd]<=ALU result.
// - All *_check outputs are combinational from current PC/RF state; valid same cycle.
// - ROM: combinational; word0=0x005303b3 (add x7,x6,x5), word1=0x40848533 (sub x10,x9,x8),
//   word2=0x00160693 (addi x13,x12,1); all other words 0x00000013 (NOP). Index wraps at IMEM_DEPTH.
// - RF: 2 async reads, 1 sync write; x0 reads 0 always, writes to x0 dropped; no write-to-read bypass.
// - alu_op encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7.
// - ALU: 32-bit, wrap-around add/sub; SLL/SRL by b[4:0] (logical); SLT signed, result 1 or 0.
// - Decode opcode 0110011 (R): funct3 000 -> ADD (funct7=0000000) / SUB (funct7=0100000); 001 SLL;
//   010 SLT; 100 XOR; 101 SRL (funct7=0); 110 OR; 111 AND; use_imm=0, reg_write=1.
// - Decode opcode 0010011 (I): ADDI/SLTI/XORI/ORI/ANDI/SLLI/SRLI same funct3 map, op B=imm_ext,
//   use_imm=1, reg_write=1; funct7 of SLLI/SRLI must be 0.
// - Unsupported opcode/funct combos (SLTU, SRA, loads, branches...): reg_write=0, alu_op=ADD,
//   use_imm=0; PC still advances by 4.
// - imm_ext = {{20{instr[31]}}, instr[31:20]} regardless of opcode.
// - reset asserted mid-run: PC and RF return to reset values at once; pending write discarded.
// CONFIGURATION
// - RF_RESET_PATTERN_EN defined: on reset x[i]=RF_INIT_BASE+i for i=1..31 (x6=3006, x12=3012).
// - RF_RESET_PATTERN_EN undefined: on reset all x[i]=0.
// - ROM contents and all other behaviour identical in both builds.
// TESTING (build with RF_RESET_PATTERN_EN)
// - ALU standalone a=4,b=2: ADD 6, SUB 2, AND 0, OR 6, XOR 6, SLL 16, SRL 1, SLT 0; a=-1,b=0 SLT -> 1.
// - Hold reset low, release: pc=0, instr=0x005303b3, op=ADD, rd1=3006, rd2=3005, result=6011, use_imm=0.
// - Next posedge: pc=4, instr=0x40848533, op=SUB, rd1=3009, rd2=3008, result=1; x7 now 6011.
// - Next posedge: pc=8, op=ADD, use_imm=1, imm_ext=1, rd1=3012, b_input=1, result=3013; then x13=3013.
// - Run past pc=8: NOP words, reg_write=1 with rd=0, x0 stays 0, pc steps 12,16,...
// - Assert reset low mid-run, between edges: pc=0 immediately, x7 back to 3007, no write on next edge.

Source files
------------

// File: rtl/rv32i_lite_core.sv
// rv32i_lite_core: single-cycle RV32I subset core (R-type and I-type ALU ops).
// PC, combinational instruction ROM, 32x32 register file, decoder,
// immediate sign-extension and ALU. One instruction retires per clock.
// Optional build macro: RF_RESET_PATTERN_EN. When defined, reset loads
// x[i] = RF_INIT_BASE + i for i = 1..31; when undefined, reset clears them.
// Datapath internals are exposed on the *_check outputs.

// Combinational 32-bit ALU.
// Op codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7.
module rv32i_alu (
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  // Select the result for the decoded operation.
  always_comb begin
    o_y = '0;
    case (i_op)
      3'd0: o_y = i_a + i_b;
      3'd1: o_y = i_a - i_b;
      3'd2: o_y = i_a & i_b;
      3'd3: o_y = i_a | i_b;
      3'd4: o_y = i_a ^ i_b;
      3'd5: o_y = i_a << i_b[4:0];
      3'd6: o_y = i_a >> i_b[4:0];
      3'd7: o_y = {31'd0, ($signed(i_a) < $signed(i_b))};
      default: o_y = '0;
    endcase
  end

endmodule

module rv32i_lite_core #(
  parameter int IMEM_DEPTH   = 64,
  parameter int RF_INIT_BASE = 3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out_check,
  output logic [31:0] instruction_check,
  output logic [2:0]  alu_op_check,
  output logic [31:0] register_data_out1_check,
  output logic [31:0] register_data_out2_check,
  output logic [31:0] b_input_check,
  output logic [31:0] register_data_in_check,
  output logic [31:0] alu_result_check,
  output logic        reg_write_check,
  output logic [31:0] imm_ext_check,
  output logic        use_imm_check
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

`ifdef RF_RESET_PATTERN_EN
  localparam bit PATTERN_EN = 1'b1;
`else
  localparam bit PATTERN_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic [31:0] r_pc;
  logic [31:0] r_rf [1:31];

  logic [IDX_W-1:0] w_rom_idx;
  logic [31:0]      w_instr;
  logic [6:0]       w_opcode;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [31:0]      w_imm_ext;
  logic [31:0]      w_rd1;
  logic [31:0]      w_rd2;
  logic [31:0]      w_b;
  logic [31:0]      w_alu_y;
  logic [2:0]       w_alu_op;
  logic             w_use_imm;
  logic             w_reg_write;

  // ROM index wraps naturally because only the low index bits of the PC are used.
  assign w_rom_idx = r_pc[IDX_W+1:2];

  // Instruction ROM: three fixed programme words, NOP everywhere else.
  always_comb begin
    w_instr = 32'h0000_0013;
    case (w_rom_idx)
      IDX_W'(0): w_instr = 32'h0053_03b3; // add  x7, x6, x5
      IDX_W'(1): w_instr = 32'h4084_8533; // sub  x10, x9, x8
      IDX_W'(2): w_instr = 32'h0016_0693; // addi x13, x12, 1
      default:   w_instr = 32'h0000_0013; // addi x0, x0, 0
    endcase
  end

  assign w_opcode  = w_instr[6:0];
  assign w_rd      = w_instr[11:7];
  assign w_funct3  = w_instr[14:12];
  assign w_rs1     = w_instr[19:15];
  assign w_rs2     = w_instr[24:20];
  assign w_funct7  = w_instr[31:25];
  assign w_imm_ext = {{20{w_instr[31]}}, w_instr[31:20]};

  // Register file reads; x0 is hard-wired to zero, no write-to-read bypass.
  assign w_rd1 = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

  // Decode: unsupported encodings fall through as a no-write ADD on rs2.
  always_comb begin
    w_alu_op    = OP_ADD;
    w_use_imm   = 1'b0;
    w_reg_write = 1'b0;
    if (w_opcode == OPC_R) begin
      case (w_funct3)
        3'b000: begin
          if (w_funct7 == 7'b0000000) begin
            w_alu_op = OP_ADD; w_reg_write = 1'b1;
          end else if (w_funct7 == 7'b0100000) begin
            w_alu_op = OP_SUB; w_reg_write = 1'b1;
          end
        end
        3'b001: if (w_funct7 == 7'd0) begin w_alu_op = OP_SLL; w_reg_write = 1'b1; end
        3'b010: if (w_funct7 == 7'd0) begin w_alu_op = OP_SLT; w_reg_write = 1'b1; end
        3'b100: if (w_funct7 == 7'd0) begin w_alu_op = OP_XOR; w_reg_write = 1'b1; end
        3'b101: if (w_funct7 == 7'd0) begin w_alu_op = OP_SRL; w_reg_write = 1'b1; end
        3'b110: if (w_funct7 == 7'd0) begin w_alu_op = OP_OR;  w_reg_write = 1'b1; end
        3'b111: if (w_funct7 == 7'd0) begin w_alu_op = OP_AND; w_reg_write = 1'b1; end
        default: ; // SLTU and anything else: no write
      endcase
    end else if (w_opcode == OPC_I) begin
      case (w_funct3)
        3'b000: begin w_alu_op = OP_ADD; w_use_imm = 1'b1; w_reg_write = 1'b1; end
        3'b010: begin w_alu_op = OP_SLT; w_use_imm = 1'b1; w_reg_write = 1'b1; end
        3'b100: begin w_alu_op = OP_XOR; w_use_imm = 1'b1; w_reg_write = 1'b1; end
        3'b110: begin w_alu_op = OP_OR;  w_use_imm = 1'b1; w_reg_write = 1'b1; end
        3'b111: begin w_alu_op = OP_AND; w_use_imm = 1'b1; w_reg_write = 1'b1; end
        3'b001: if (w_funct7 == 7'd0) begin
          w_alu_op = OP_SLL; w_use_imm = 1'b1; w_reg_write = 1'b1;
        end
        3'b101: if (w_funct7 == 7'd0) begin
          w_alu_op = OP_SRL; w_use_imm = 1'b1; w_reg_write = 1'b1;
        end
        default: ; // SLTIU and anything else: no write
      endcase
    end
  end

  assign w_b = w_use_imm ? w_imm_ext : w_rd2;

  rv32i_alu u_alu (
    .i_op (w_alu_op),
    .i_a  (w_rd1),
    .i_b  (w_b),
    .o_y  (w_alu_y)
  );

  // PC advances by 4 every cycle; async reset returns it to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pc <= 32'd0;
    else        r_pc <= r_pc + 32'd4;
  end

  // Register file write port; reset reloads the reset pattern and drops any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++)
        r_rf[i] <= PATTERN_EN ? 32'(RF_INIT_BASE + i) : 32'd0;
    end else if (w_reg_write && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_alu_y;
    end
  end

  assign pc_out_check             = r_pc;
  assign instruction_check        = w_instr;
  assign alu_op_check             = w_alu_op;
  assign register_data_out1_check = w_rd1;
  assign register_data_out2_check = w_rd2;
  assign b_input_check            = w_b;
  assign register_data_in_check   = w_alu_y;
  assign alu_result_check         = w_alu_y;
  assign reg_write_check          = w_reg_write;
  assign imm_ext_check            = w_imm_ext;
  assign use_imm_check            = w_use_imm;

endmodule

// File: tb/tb_rv32i_lite_core.sv
// Testbench for rv32i_lite_core: standalone ALU vector table, a table of
// per-instruction datapath expectations for the ROM programme, plus
// hand-written sequences for mid-run reset and ROM index wrap.
// Expected register reset values follow RF_RESET_PATTERN_EN.
`timescale 1ns/1ps
module tb_rv32i_lite_core;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out_check;
  logic [31:0] instruction_check;
  logic [2:0]  alu_op_check;
  logic [31:0] register_data_out1_check;
  logic [31:0] register_data_out2_check;
  logic [31:0] b_input_check;
  logic [31:0] register_data_in_check;
  logic [31:0] alu_result_check;
  logic        reg_write_check;
  logic [31:0] imm_ext_check;
  logic        use_imm_check;

  logic [2:0]  alu_op_in;
  logic [31:0] alu_a_in;
  logic [31:0] alu_b_in;
  logic [31:0] alu_y;

  int checks = 0;
  int errors = 0;

  rv32i_lite_core dut (
    .clk                      (clk),
    .reset                    (reset),
    .pc_out_check             (pc_out_check),
    .instruction_check        (instruction_check),
    .alu_op_check             (alu_op_check),
    .register_data_out1_check (register_data_out1_check),
    .register_data_out2_check (register_data_out2_check),
    .b_input_check            (b_input_check),
    .register_data_in_check   (register_data_in_check),
    .alu_result_check         (alu_result_check),
    .reg_write_check          (reg_write_check),
    .imm_ext_check            (imm_ext_check),
    .use_imm_check            (use_imm_check)
  );

  rv32i_alu u_alu_alone (
    .i_op (alu_op_in),
    .i_a  (alu_a_in),
    .i_b  (alu_b_in),
    .o_y  (alu_y)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] xinit(input int i);
`ifdef RF_RESET_PATTERN_EN
    return 32'(3000 + i);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } alu_vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
  } core_vec_t;

  alu_vec_t  alu_tab [0:10];
  core_vec_t core_tab [0:4];

  task automatic check_core(input core_vec_t v, input string tag);
    check32({tag, ".pc"},        pc_out_check, v.pc);
    check32({tag, ".instr"},     instruction_check, v.instr);
    check32({tag, ".op"},        {29'd0, alu_op_check}, {29'd0, v.op});
    check32({tag, ".rd1"},       register_data_out1_check, v.rd1);
    check32({tag, ".rd2"},       register_data_out2_check, v.rd2);
    check32({tag, ".b_input"},   b_input_check, v.b);
    check32({tag, ".result"},    alu_result_check, v.res);
    check32({tag, ".wb_data"},   register_data_in_check, v.res);
    check32({tag, ".imm_ext"},   imm_ext_check, v.imm);
    check32({tag, ".use_imm"},   {31'd0, use_imm_check}, {31'd0, v.use_imm});
    check32({tag, ".reg_write"}, {31'd0, reg_write_check}, {31'd0, v.reg_write});
  endtask

  initial begin
    logic [31:0] x7_new;
    logic [31:0] x13_new;

    // ALU standalone vectors
    alu_tab[0]  = '{3'd0, 32'd4, 32'd2, 32'd6};
    alu_tab[1]  = '{3'd1, 32'd4, 32'd2, 32'd2};
    alu_tab[2]  = '{3'd2, 32'd4, 32'd2, 32'd0};
    alu_tab[3]  = '{3'd3, 32'd4, 32'd2, 32'd6};
    alu_tab[4]  = '{3'd4, 32'd4, 32'd2, 32'd6};
    alu_tab[5]  = '{3'd5, 32'd4, 32'd2, 32'd16};
    alu_tab[6]  = '{3'd6, 32'd4, 32'd2, 32'd1};
    alu_tab[7]  = '{3'd7, 32'd4, 32'd2, 32'd0};
    alu_tab[8]  = '{3'd7, 32'hFFFF_FFFF, 32'd0, 32'd1};
    alu_tab[9]  = '{3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0};
    alu_tab[10] = '{3'd6, 32'h8000_0000, 32'd33, 32'h4000_0000};

    // Core programme expectations, derived from the reset register values
    x7_new  = xinit(6) + xinit(5);
    x13_new = xinit(12) + 32'd1;
    core_tab[0] = '{32'd0,  32'h0053_03b3, 3'd0, xinit(6),  xinit(5), xinit(5), x7_new,
                    32'd5, 1'b0, 1'b1};
    core_tab[1] = '{32'd4,  32'h4084_8533, 3'd1, xinit(9),  xinit(8), xinit(8),
                    xinit(9) - xinit(8), 32'd1032, 1'b0, 1'b1};
    core_tab[2] = '{32'd8,  32'h0016_0693, 3'd0, xinit(12), xinit(1), 32'd1, x13_new,
                    32'd1, 1'b1, 1'b1};
    core_tab[3] = '{32'd12, 32'h0000_0013, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                    32'd0, 1'b1, 1'b1};
    core_tab[4] = '{32'd16, 32'h0000_0013, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                    32'd0, 1'b1, 1'b1};

    reset     = 1'b0;
    alu_op_in = '0;
    alu_a_in  = '0;
    alu_b_in  = '0;

    for (int k = 0; k < 11; k++) begin
      alu_op_in = alu_tab[k].op;
      alu_a_in  = alu_tab[k].a;
      alu_b_in  = alu_tab[k].b;
      #1;
      check32($sformatf("alu[%0d]", k), alu_y, alu_tab[k].y);
    end

    // Held in reset across clock edges
    repeat (2) @(negedge clk);
    check32("reset.pc", pc_out_check, 32'd0);
    check32("reset.x7", dut.r_rf[7], xinit(7));

    // Release between edges and walk the programme
    reset = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_core(core_tab[k], $sformatf("step%0d", k));
      @(negedge clk);
      if (k == 0) check32("x7_written", dut.r_rf[7], x7_new);
      if (k == 2) check32("x13_written", dut.r_rf[13], x13_new);
    end
    check32("pc_after_nops", pc_out_check, 32'd20);
    check32("x7_kept", dut.r_rf[7], x7_new);

    // Mid-run reset between edges: immediate effect, no write on next edge
    #2;
    reset = 1'b0;
    #1;
    check32("midreset.pc", pc_out_check, 32'd0);
    check32("midreset.x7", dut.r_rf[7], xinit(7));
    check32("midreset.x13", dut.r_rf[13], xinit(13));
    @(negedge clk);
    check32("midreset_edge.pc", pc_out_check, 32'd0);
    check32("midreset_edge.x7", dut.r_rf[7], xinit(7));
    reset = 1'b1;
    #1;
    check_core(core_tab[0], "rerun0");

    // ROM index wraps after IMEM_DEPTH words
    repeat (64) @(negedge clk);
    check32("wrap.pc", pc_out_check, 32'd256);
    check32("wrap.instr", instruction_check, 32'h0053_03b3);
    check32("wrap.x7", dut.r_rf[7], x7_new);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
